// File: rtl/spi_slave_fsm.sv
// SPI slave front-end: deserialises 10-bit MOSI frames into rx_data/rx_valid
// for the RAM stage and shifts RAM read bytes out MSB-first on MISO.
// Ports: clk, rst (sync, active-high), SS_n, MOSI, MISO,
//        rx_data[MEM_WIDTH+1:0], rx_valid, tx_data[MEM_WIDTH-1:0], tx_valid.
// Optional macro SPI_SLAVE_TX_TIMEOUT_EN: abandon RD_WAIT after TX_TIMEOUT
// cycles without tx_valid.
module spi_slave_fsm #(
   parameter int MEM_WIDTH  = 8,
   parameter int TX_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [MEM_WIDTH+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [MEM_WIDTH-1:0] tx_data,
   input  logic                 tx_valid
);

   localparam int FW = MEM_WIDTH + 2;
   localparam logic [3:0] RX_LAST = 4'(FW - 2);
   localparam logic [3:0] TX_LAST = 4'(MEM_WIDTH - 1);
   localparam logic [3:0] TO_LAST = 4'(TX_TIMEOUT - 1);

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA,
      RD_WAIT,
      RD_SHIFT,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [FW-2:0]          shift_q, shift_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [3:0]             to_cnt_q, to_cnt_d;
   logic                   seen_q, seen_d;
   logic [FW-1:0]          rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   miso_q, miso_d;
   logic [MEM_WIDTH-2:0]   tx_shift_q, tx_shift_d;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      to_cnt_d   = to_cnt_q;
      seen_d     = seen_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      miso_d     = miso_q;
      tx_shift_d = tx_shift_q;

      // Deselect aborts whatever is in flight; seen flag survives.
      if (SS_n) begin
         state_d = IDLE;
         miso_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               miso_d  = 1'b0;
               state_d = CHK_CMD;
            end
            CHK_CMD: begin
               shift_d = {{(FW-2){1'b0}}, MOSI};
               cnt_d   = '0;
               if (!MOSI)
                  state_d = WRITE;
               else if (seen_q)
                  state_d = READ_DATA;
               else
                  state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               shift_d = {shift_q[FW-3:0], MOSI};
               if (cnt_q == RX_LAST) begin
                  // Frame forwarded as received; control bits not checked.
                  rx_data_d  = {shift_q, MOSI};
                  rx_valid_d = 1'b1;
                  cnt_d      = '0;
                  to_cnt_d   = '0;
                  if (state_q == READ_ADD) begin
                     seen_d  = 1'b1;
                     state_d = DONE;
                  end else if (state_q == READ_DATA) begin
                     seen_d  = 1'b0;
                     state_d = RD_WAIT;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            RD_WAIT: begin
               // tx_valid wins over a same-edge timeout expiry.
               if (tx_valid) begin
                  miso_d     = tx_data[MEM_WIDTH-1];
                  tx_shift_d = tx_data[MEM_WIDTH-2:0];
                  cnt_d      = '0;
                  state_d    = RD_SHIFT;
               end else if (TO_EN) begin
                  if (to_cnt_q == TO_LAST) begin
                     miso_d  = 1'b0;
                     state_d = DONE;
                  end else begin
                     to_cnt_d = to_cnt_q + 4'd1;
                  end
               end
            end
            RD_SHIFT: begin
               if (cnt_q == TX_LAST) begin
                  miso_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  miso_d     = tx_shift_q[MEM_WIDTH-2];
                  tx_shift_d = {tx_shift_q[MEM_WIDTH-3:0], 1'b0};
                  cnt_d      = cnt_q + 4'd1;
               end
            end
            DONE: begin
               miso_d = 1'b0;
            end
            default: begin
               miso_d  = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         to_cnt_q   <= '0;
         seen_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
         tx_shift_q <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         to_cnt_q   <= to_cnt_d;
         seen_q     <= seen_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave_fsm.md
# spi_slave_fsm

SPI slave front-end that deserialises MOSI frames into 10-bit command/data words for the single-port RAM stage. It pulses `rx_valid` with `rx_data` for each complete frame. For read-data commands it waits for the RAM's `tx_valid`/`tx_data` response and serialises the byte MSB-first on MISO. It sits directly upstream of the RAM and is the slave-side endpoint of the SPI bus.

## Interface
Parameters:
- `MEM_WIDTH`, default 8: RAM word width; `rx_data` is `MEM_WIDTH+2` bits wide.
- `TX_TIMEOUT`, default 15: cycles to wait for `tx_valid` (used only with the macro).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `SS_n` in 1: slave select, active low.
- `MOSI` in 1: serial data in.
- `MISO` out 1: serial data out.
- `rx_data` out `MEM_WIDTH+2`: completed frame; bits [9:8] are the control code (00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA).
- `rx_valid` out 1: one-cycle strobe qualifying `rx_data`.
- `tx_data` in `MEM_WIDTH`: read byte from the RAM.
- `tx_valid` in 1: strobe qualifying `tx_data`.

## Operation
- All outputs are registered. Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, state=IDLE, `rd_addr_seen`=0, counters=0.
- States and transitions:
  - **IDLE**: moves to CHK_CMD when `SS_n`=0 is sampled.
  - **CHK_CMD**: samples `MOSI` as frame bit 9 into the shift register.
    - `MOSI`=0 → WRITE.
    - `MOSI`=1 and `rd_addr_seen`=0 → READ_ADD.
    - `MOSI`=1 and `rd_addr_seen`=1 → READ_DATA.
  - **WRITE / READ_ADD / READ_DATA**: shift in 9 more bits MSB-first, one per edge.
    - On the edge capturing bit 0: `rx_data` ← full 10-bit frame, `rx_valid` ← 1 for exactly one cycle.
    - The frame is forwarded verbatim; control bits are not checked against the state.
  - **After WRITE**: → DONE.
  - **After READ_ADD**: `rd_addr_seen` ← 1, → DONE.
  - **After READ_DATA**: `rd_addr_seen` ← 0, → RD_WAIT.
  - **RD_WAIT**: on sampled `tx_valid`=1, `MISO` ← `tx_data[7]`, low 7 bits are loaded into the out-shift register, → RD_SHIFT.
  - **RD_SHIFT**: shifts out the remaining 7 bits, one per edge, then `MISO` ← 0 and → DONE.
  - **DONE**: holds `MISO`=0 and ignores `MOSI` until `SS_n`=1.
- `SS_n`=1 sampled in any state → IDLE on that edge.
  - Partial frames are discarded; no `rx_valid` is issued.
  - `MISO` ← 0.
  - `rd_addr_seen` is kept.
- `tx_valid` outside RD_WAIT is ignored.
- `rst` overrides everything, including mid-frame and mid-shift-out.

## Timing
- `SS_n` falls before edge E0 → state is CHK_CMD after E0.
- Frame bit 9 is captured at E1; bit 0 at E10. `rx_valid`=1 during the cycle after E10.
- RAM responds with `tx_valid` at edge E11 or later.
- With `tx_valid` sampled at edge T: `tx_data[7]` is on `MISO` after T, `tx_data[0]` after T+7, and `MISO`=0 after T+8.
- Minimum SPI read-data transaction: 1 + 10 + RAM latency + 8 cycles.
- `rx_valid` never asserts on two consecutive cycles.

## Configuration
- Macro: `SPI_SLAVE_TX_TIMEOUT_EN`.
- **Defined**: a 4-bit counter runs in RD_WAIT. If `TX_TIMEOUT` cycles elapse without `tx_valid`, the FSM moves to DONE with `MISO`=0. A `tx_valid` on the same edge as expiry wins.
- **Undefined**: RD_WAIT waits indefinitely, exiting only on `tx_valid`, `SS_n`=1 or `rst`.

## Test plan
- Reset mid-frame (`rst`=1 after 5 bits) → `rx_valid` never pulses, `MISO`=0, next frame decodes normally.
- WR_ADDR frame 00_0000_0101 → one `rx_valid` pulse with `rx_data`=10'h005, then DONE until `SS_n` rises.
- RD_ADDR frame 10_0000_0101, then read frame 11_xxxx_xxxx → second frame is routed through READ_DATA. Return `tx_valid` with `tx_data`=8'hA5 → MISO sequence 1,0,1,0,0,1,0,1 on consecutive cycles, then 0.
- Read frame without a prior RD_ADDR → state is READ_ADD, `rd_addr_seen` becomes 1, no MISO activity.
- `SS_n` deasserted after 6 frame bits → IDLE next edge, no `rx_valid`; a following full frame produces exactly one `rx_valid`.
- With `SPI_SLAVE_TX_TIMEOUT_EN` defined and `tx_valid` withheld → DONE after 15 cycles in RD_WAIT, `MISO` stays 0. Without the macro, the FSM is still in RD_WAIT after 100 cycles.
